// File: rtl/tl_pkg.sv
// Shared constants for the traffic-light sequencer: state codes, light codes
// and the state-to-lights decode used by tl_sequencer.
package tl_pkg;

  localparam logic [1:0] s0 = 2'b00;
  localparam logic [1:0] s1 = 2'b01;
  localparam logic [1:0] s2 = 2'b10;
  localparam logic [1:0] s3 = 2'b11;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] OFF    = 2'b11;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } lights_t;

  function automatic lights_t decode_lights(input logic [1:0] st);
    lights_t lit;
    case (st)
      s0:      lit = '{a: GREEN,  b: RED};
      s1:      lit = '{a: YELLOW, b: RED};
      s2:      lit = '{a: RED,    b: GREEN};
      default: lit = '{a: RED,    b: YELLOW};
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/tl_dwell_cnt.sv
// Dwell counter: counts cycles spent in the current state, saturating at 255.
// Clear has priority over enable.
module tl_dwell_cnt (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] count
);

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values, independent of always-block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/tl_sequencer.sv
// Traffic-light sequencer: guards requested transitions with minimum-green and
// fixed-yellow dwell times. Optional flashing mode under macro TL_FLASH_EN.
module tl_sequencer
  import tl_pkg::*;
#(
  parameter int YELLOW_CYCLES    = 5,
  parameter int MIN_GREEN_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef TL_FLASH_EN
  input  logic       flash,
`endif
  input  logic [1:0] nextstate,
  output logic [1:0] state,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       advance,
  output logic       seq_err
);

  localparam logic [7:0] YEL_LAST = 8'(YELLOW_CYCLES - 1);
  localparam logic [7:0] GRN_LAST = 8'(MIN_GREEN_CYCLES - 1);

  logic [7:0] dwell;
  logic [1:0] succ;
  logic       freeze;
  logic       resume;
  logic       change;
  logic       illegal;
  lights_t    lit;

  assign succ = state + 2'd1;

`ifdef TL_FLASH_EN
  logic       flash_q;
  logic [3:0] blink_cnt;

  // The release edge is also frozen so the first cycle back starts at dwell 0.
  assign freeze = flash | flash_q;
  assign resume = flash_q & ~flash;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flash_q   <= 1'b0;
      blink_cnt <= '0;
    end else begin
      flash_q   <= flash;
      blink_cnt <= flash_q ? blink_cnt + 4'd1 : 4'd0;
    end
  end
`else
  assign freeze = 1'b0;
  assign resume = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    change  = 1'b0;
    illegal = 1'b0;
    if (!freeze) begin
      illegal = (nextstate != state) && (nextstate != succ);
      if (state[0]) begin
        change = (dwell == YEL_LAST);
      end else begin
        change = (nextstate == succ) && (dwell >= GRN_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= s0;
      advance <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      if (change) begin
        state <= succ;
      end
      advance <= change;
      seq_err <= seq_err | illegal;
    end
  end

  tl_dwell_cnt u_dwell (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (change | resume),
    .enable (~freeze),
    .count  (dwell)
  );

  // Lights depend on registers only, never directly on inputs.
  always_comb begin
    lit = decode_lights(state);
`ifdef TL_FLASH_EN
    if (flash_q) begin
      lit = blink_cnt[3] ? '{a: OFF, b: OFF} : '{a: YELLOW, b: YELLOW};
    end
`endif
  end

  assign La = lit.a;
  assign Lb = lit.b;

endmodule

// File: doc/tl_sequencer.md
TL_SEQUENCER -- requirements
Module: tl_sequencer

Interface
REQ-001 Parameter YELLOW_CYCLES, default 5, sets the exact dwell of s1/s3 in clock cycles (legal range 1..255).
REQ-002 Parameter MIN_GREEN_CYCLES, default 10, sets the minimum dwell of s0/s2 in clock cycles (legal range 1..255).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port nextstate, input, 2 bits: requested successor state from the next-state logic.
REQ-006 Port state, output, 2 bits: registered current state, fed back to the next-state logic.
REQ-007 Port La, output, 2 bits: street A light, encoded 00 green, 01 yellow, 10 red.
REQ-008 Port Lb, output, 2 bits: street B light, same encoding as La.
REQ-009 Port advance, output, 1 bit: one-cycle pulse in the cycle after state changes.
REQ-010 Port seq_err, output, 1 bit: sticky flag indicating an illegal transition request.

Function
REQ-011 The block SHALL decode lights from state: s0 La=00/Lb=10, s1 La=01/Lb=10, s2 La=10/Lb=00, s3 La=10/Lb=01.
REQ-012 An internal dwell counter SHALL clear to 0 on every state change and increment each cycle otherwise, saturating at 255.
REQ-013 In s1/s3, state SHALL advance to (state+1) mod 4 on the edge where dwell = YELLOW_CYCLES-1, regardless of nextstate.
REQ-014 In s0/s2, state SHALL load nextstate only when nextstate = state+1 and dwell >= MIN_GREEN_CYCLES-1.
REQ-015 In s0/s2, an early legal request SHALL be held off without error; state is taken on the first edge at which REQ-014 holds and nextstate is still legal.
REQ-016 nextstate = state SHALL hold state with no error.
REQ-017 nextstate not in {state, state+1 mod 4} SHALL be ignored (state holds) and SHALL set seq_err, which remains 1 until reset.
REQ-018 advance SHALL be registered: high for exactly the one cycle following each state update, otherwise low.
REQ-019 La, Lb, and state SHALL be glitch-free decodes of the state register only (no input-to-output combinational path).

Reset
REQ-020 While reset_n = 0: state = s0, dwell = 0, advance = 0, seq_err = 0, La = 00, Lb = 10.
REQ-021 Reset assertion mid-dwell or mid-yellow SHALL abort immediately, asynchronously; the first edge after release counts as dwell 0 of s0.

Configuration
REQ-022 With macro TL_FLASH_EN defined, the module SHALL add input port flash (1 bit), placed after reset_n.
REQ-023 When flash = 1, La and Lb SHALL both toggle between 01 and 11 (off) every 8 cycles; state and dwell freeze, and nextstate is ignored, with no seq_err.
REQ-024 On flash 1->0, the module SHALL resume in the frozen state, with dwell cleared to 0.
REQ-025 Without TL_FLASH_EN, the flash port and the blink logic SHALL be absent, and the behaviour is exactly REQ-011..REQ-019.

Structure
REQ-026 A shared package tl_pkg SHALL hold the state constants s0..s3 (2'b00..2'b11) and the light codes GREEN/YELLOW/RED/OFF.
REQ-027 The dwell counter SHALL be a sub-module tl_dwell_cnt (clear, enable, 8-bit count out); the decode and state register remain in tl_sequencer.

Verification
REQ-028 Reset test: hold reset_n low for 3 cycles, then release with nextstate = 00 -> state = 00, La = 00, Lb = 10, advance = 0, seq_err = 0.
REQ-029 Minimum green hold: with defaults, drive nextstate = 01 from cycle 0 after reset -> state becomes 01 on the 10th edge, and advance pulses once on the next cycle.
REQ-030 Yellow dwell: once in s1, drive nextstate = 01 constantly -> state = 10 exactly 5 edges later; La = 10 and Lb = 00.
REQ-031 Full cycle: Ta = 0 and Tb = 0 equivalents, with nextstate = state+1 always -> sequence 00,01,10,11,00 with dwell lengths 10,5,10,5.
REQ-032 Illegal request: in s0 after 12 cycles, drive nextstate = 10 -> state stays 00 and seq_err = 1, persisting until reset_n pulses low.
REQ-033 TL_FLASH_EN: in s2, assert flash for 20 cycles -> La and Lb alternate 01/11 every 8 cycles and state stays 10; after release, state advances only after 10 more cycles.
